mac_result_collector: RTL and testbench

- Downstream stage of the pipelined signed 32x32 multiplier (operands A/B in, 64-bit product P out, fixed latency).
- Tracks which multiplier cycles carry valid products, and accumulates groups ("vectors") of products into dot-product sums.
- Each finished sum is buffered and presented to the consumer over a valid/ready handshake.
- Drives issue-side backpressure so that no in-flight product is ever lost.

---
 rtl/mac_result_collector.sv | 147 ++++++++++++++
 tb/tb_mac_result_collector.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_collector.sv
// Collects products from a fixed-latency multiplier, sums them into dot-product vectors,
// buffers finished vectors in a 2-entry FIFO and throttles the issuer so no product is dropped.
module mac_result_collector #(
    parameter int PW  = 64,
    parameter int AW  = 72,
    parameter int CW  = 8,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_last,
    output logic          issue_ready,
    input  logic [PW-1:0] P,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    localparam int PCW = $clog2(LAT + 1) + 2;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t          state_q;
    logic [LAT-1:0]  tagValid_q, tagLast_q;
    logic            tagValid, tagLast;
    logic [AW-1:0]   pExt, accSum;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            push, pop;
    logic [AW-1:0]   sumMem_q [2];
    logic [CW-1:0]   cntMem_q [2];
    logic            ovfMem_q [2];
    logic            wrPtr_q, rdPtr_q;
    logic [1:0]      fifoCount_q;
    logic [PCW-1:0]  pend, occupancy;

    assign tagValid = tagValid_q[LAT-1];
    assign tagLast  = tagLast_q[LAT-1];
    assign pExt     = {{(AW-PW){P[PW-1]}}, P};
    assign accSum   = acc_q + pExt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagValid_q <= '0;
            tagLast_q  <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagLast_q[i]  <= tagLast_q[i-1];
            end
            tagValid_q[0] <= issue_valid & issue_ready;
            tagLast_q[0]  <= issue_last;
        end
    end

    // A new vector starts from the sign-extended product; later terms wrap and flag overflow.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        push  = 1'b0;
        if (tagValid) begin
            if (state_q == IDLE) begin
                acc_d = pExt;
                cnt_d = CW'(1);
                ovf_d = 1'b0;
            end else begin
                acc_d = accSum;
                ovf_d = ovf_q | ((acc_q[AW-1] == pExt[AW-1]) && (accSum[AW-1] != acc_q[AW-1]));
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            push = tagLast;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (tagValid) begin
                state_q <= tagLast ? IDLE : ACCUM;
            end
        end
    end

    assign pop = out_valid & out_ready;

    // When full, a simultaneous push overwrites the slot being popped, so order is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            fifoCount_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                sumMem_q[i] <= '0;
                cntMem_q[i] <= '0;
                ovfMem_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                sumMem_q[wrPtr_q] <= acc_d;
                cntMem_q[wrPtr_q] <= cnt_d;
                ovfMem_q[wrPtr_q] <= ovf_d;
                wrPtr_q           <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({push, pop})
                2'b10:   fifoCount_q <= fifoCount_q + 2'd1;
                2'b01:   fifoCount_q <= fifoCount_q - 2'd1;
                default: fifoCount_q <= fifoCount_q;
            endcase
        end
    end

    assign out_valid = (fifoCount_q != 2'd0);
    assign out_sum   = out_valid ? sumMem_q[rdPtr_q] : '0;
    assign out_count = out_valid ? cntMem_q[rdPtr_q] : '0;
    assign out_ovf   = out_valid ? ovfMem_q[rdPtr_q] : 1'b0;

    // Every vector end still in flight must already own a FIFO slot.
    always_comb begin
        pend = '0;
        for (int i = 0; i < LAT; i++) begin
            pend = pend + PCW'(tagValid_q[i] & tagLast_q[i]);
        end
    end

    assign occupancy   = pend + PCW'(fifoCount_q);
    assign issue_ready = (occupancy < PCW'(2));

endmodule

// File: tb/tb_mac_result_collector.sv
// Drives two collectors (AW=72 and AW=65) with shared stimulus and compares them against
// a queue-based model of issued vectors, their expected sums and their arrival cycles.
module tb_mac_result_collector;

    localparam int LAT = 2;

    typedef struct {
        logic [127:0] sumA;
        logic         ovfA;
        logic [127:0] sumB;
        logic         ovfB;
        int           count;
        int           readyCyc;
    } result_t;

    logic        clk, rst, issue_valid, issue_last, out_ready;
    logic [63:0] P, productIn;
    logic        issueReadyA, issueReadyB, outValidA, outValidB;
    logic [71:0] outSumA;
    logic [64:0] outSumB;
    logic [7:0]  outCountA, outCountB;
    logic        outOvfA, outOvfB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit readySnap = 1'b1;
    bit validSnap = 1'b0;
    bit randMode = 1'b0;

    result_t             expQ[$];
    result_t             newRes;
    logic signed [63:0]  terms[$];
    logic [63:0]         pPipe [LAT];

    assign P = pPipe[LAT-1];

    mac_result_collector #(.PW(64), .AW(72), .CW(8), .LAT(LAT)) dutA (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
        .issue_ready(issueReadyA), .P(P), .out_valid(outValidA), .out_ready(out_ready),
        .out_sum(outSumA), .out_count(outCountA), .out_ovf(outOvfA)
    );

    mac_result_collector #(.PW(64), .AW(65), .CW(8), .LAT(LAT)) dutB (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
        .issue_ready(issueReadyB), .P(P), .out_valid(outValidB), .out_ready(out_ready),
        .out_sum(outSumB), .out_count(outCountB), .out_ovf(outOvfB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Exact running sum, wrapped to aw bits whenever it leaves the signed range.
    function automatic void calcSum(input logic signed [63:0] t[$], input int aw,
                                    output logic [127:0] sum, output logic ovf);
        logic signed [127:0] acc, lim;
        acc = '0;
        ovf = 1'b0;
        lim = 128'sd1 <<< (aw - 1);
        foreach (t[i]) begin
            acc = acc + {{64{t[i][63]}}, t[i]};
            if (acc >= lim) begin
                acc = acc - (lim <<< 1);
                ovf = 1'b1;
            end else if (acc < -lim) begin
                acc = acc + (lim <<< 1);
                ovf = 1'b1;
            end
        end
        sum = acc & ((128'd1 << aw) - 128'd1);
    endfunction

    function automatic logic [63:0] mul(input int a, input int b);
        return 64'(longint'(a) * longint'(b));
    endfunction

    function automatic logic [63:0] randProd();
        case ($urandom_range(0, 3))
            0:       return mul(int'($urandom), int'($urandom));
            1:       return {$urandom, $urandom};
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return 64'h8000_0000_0000_0000;
        endcase
    endfunction

    // Multiplier stand-in plus the reference bookkeeping of accepted terms and pops.
    always @(posedge clk) begin
        pPipe[0] <= issue_valid ? productIn : {$urandom, $urandom};
        for (int i = 1; i < LAT; i++) pPipe[i] <= pPipe[i-1];
        if (!rst) begin
            if (validSnap && out_ready) void'(expQ.pop_front());
            if (issue_valid && readySnap) begin
                terms.push_back(productIn);
                if (issue_last) begin
                    calcSum(terms, 72, newRes.sumA, newRes.ovfA);
                    calcSum(terms, 65, newRes.sumB, newRes.ovfB);
                    newRes.count = (terms.size() > 255) ? 255 : terms.size();
                    if (terms.size() > 255) begin
                        newRes.ovfA = 1'b1;
                        newRes.ovfB = 1'b1;
                    end
                    newRes.readyCyc = cyc + LAT + 1;
                    expQ.push_back(newRes);
                    terms.delete();
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit expValid, expReady;
        if (rst) begin
            readySnap = 1'b1;
            validSnap = 1'b0;
        end else begin
            expValid = (expQ.size() > 0) && (expQ[0].readyCyc <= cyc);
            expReady = (expQ.size() < 2);
            checkOutput("validA", outValidA, expValid);
            checkOutput("validB", outValidB, expValid);
            checkOutput("readyA", issueReadyA, expReady);
            checkOutput("readyB", issueReadyB, expReady);
            if (expValid) begin
                checkOutput("sumA", outSumA, expQ[0].sumA);
                checkOutput("ovfA", outOvfA, expQ[0].ovfA);
                checkOutput("countA", outCountA, expQ[0].count);
                checkOutput("sumB", outSumB, expQ[0].sumB);
                checkOutput("ovfB", outOvfB, expQ[0].ovfB);
                checkOutput("countB", outCountB, expQ[0].count);
            end
            readySnap = expReady;
            validSnap = expValid;
        end
    end

    always @(posedge clk) begin
        if (randMode) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic applyStimulus(input logic [63:0] prod, input logic last);
        int waited = 0;
        issue_valid = 1'b1;
        issue_last  = last;
        productIn   = prod;
        forever begin
            @(posedge clk);
            if (readySnap) break;
            waited++;
            if (waited >= 200) begin
                checkOutput("issueStall", 128'(waited), 128'd0);
                break;
            end
        end
        #1;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_last = 1'b0;
        out_ready = 1'b0;
        productIn = '0;
        #12;
        checkOutput("rstValid", outValidA, 0);
        checkOutput("rstReady", issueReadyA, 1);
        checkOutput("rstSum", outSumA, 0);
        checkOutput("rstCount", outCountA, 0);
        checkOutput("rstOvf", outOvfA, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        out_ready = 1'b1;
        applyStimulus(mul(10, -150), 1'b0);
        applyStimulus(mul(10, 10), 1'b0);
        applyStimulus(mul(-10, -150), 1'b1);
        repeat (LAT) @(negedge clk);
        checkOutput("latEarly", outValidA, 0);
        @(negedge clk);
        checkOutput("latValid", outValidA, 1);
        checkOutput("latCount", outCountA, 3);
        @(posedge clk);
        #1;

        applyStimulus(mul(-10, 150), 1'b1);
        applyStimulus(mul(10, 10), 1'b1);
        applyStimulus(mul(10, 150), 1'b1);
        applyStimulus(mul(-150, 150), 1'b1);
        idleCycles(6);

        out_ready = 1'b0;
        applyStimulus(mul(7, 9), 1'b1);
        applyStimulus(mul(-3, 11), 1'b1);
        fork
            applyStimulus(mul(5, 5), 1'b1);
            begin
                idleCycles(8);
                out_ready = 1'b1;
            end
        join
        idleCycles(8);

        for (int i = 0; i < 255; i++) applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        applyStimulus(64'h8000_0000_0000_0000, 1'b0);
        applyStimulus(64'h8000_0000_0000_0000, 1'b1);
        idleCycles(6);

        applyStimulus(mul(2, 4), 1'b0);
        idleCycles(3);
        applyStimulus(mul(3, 5), 1'b1);
        idleCycles(6);

        out_ready = 1'b0;
        applyStimulus(mul(4, 4), 1'b1);
        idleCycles(LAT + 2);
        applyStimulus(mul(9, 9), 1'b0);
        #3 rst = 1'b1;
        terms.delete();
        expQ.delete();
        readySnap = 1'b1;
        validSnap = 1'b0;
        #1;
        checkOutput("asyncRstValidA", outValidA, 0);
        checkOutput("asyncRstValidB", outValidB, 0);
        checkOutput("asyncRstReady", issueReadyA, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(mul(1, 150), 1'b1);
        idleCycles(6);

        randMode = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
            applyStimulus(randProd(), ($urandom_range(0, 2) == 0));
        end
        applyStimulus(randProd(), 1'b1);
        randMode = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        n = 0;
        while (expQ.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drainEmpty", 128'(expQ.size()), 128'd0);
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
